clk_time_loader: RTL and testbench
==================================

// Module: clk_time_loader
// PURPOSE
//  Initiator for the real-time clock's load interface (load/addrs/data_in).
//  Accepts one hh:mm:ss set request over a valid/ready handshake, range-checks it,
//  issues the three register writes, reads the clock outputs back and retries on mismatch.
//  Sits between the user/command front-end and the clock top-level.
// PARAMETERS
//  MAX_RETRY   3   write+verify attempts after the first one before the request is flagged failed
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   set request present
//  req_ready    out  1   loader idle, request accepted on valid&&ready
//  req_hours    in   5   requested hours, 0..23
//  req_minutes  in   6   requested minutes, 0..59
//  req_seconds  in   6   requested seconds, 0..59
//  q_seconds    in   6   clock seconds readback
//  q_minutes    in   6   clock minutes readback
//  q_hours      in   5   clock hours readback
//  load         out  1   write strobe to clock, one-cycle pulse per write
//  addrs        out  2   write target: 2'b00 seconds, 2'b01 minutes, 2'b10 hours; 2'b11 never driven
//  data_in      out  6   write data; hours zero-extended in bit 5
//  done         out  1   one-cycle pulse, request loaded and verified
//  error        out  1   one-cycle pulse, request rejected (range) or retries exhausted
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, req_ready=1, load=0, addrs=2'b00,
//   data_in=0, done=0, error=0, retry count=0, captured request=0.
//  req_ready=1 only in IDLE. On valid&&ready, capture all three fields in that cycle.
//  States: IDLE -> CHECK -> WR_HR -> WR_MIN -> WR_SEC -> VERIFY -> IDLE.
//  CHECK (1 cycle): hours>23 or minutes>59 or seconds>59 -> pulse error, go IDLE, no writes.
//  WR_HR/WR_MIN/WR_SEC: one cycle each, load=1 with matching addrs/data_in; writes are
//   registered outputs, back-to-back, order fixed hours, minutes, seconds (seconds last
//   so a base tick between writes cannot carry into an already-written field).
//  VERIFY: waits one cycle after the WR_SEC strobe, then compares q_* to captured values.
//   Match: seconds == captured, or seconds == captured+1 with minutes/hours equal, or
//   captured==59 and the readback equals the correctly carried value (00, min+1 mod 60,
//   hours+1 mod 24 as applicable) -> pulse done, go IDLE.
//   Mismatch: retry count < MAX_RETRY -> increment, back to WR_HR; else pulse error, IDLE.
//  Latency, clean request: accept at cycle 0, CHECK 1, writes 2-4, compare 6, done high 6.
//  load low in every state except WR_*; addrs/data_in hold last value when load=0.
//  done and error never assert in the same cycle; both are single-cycle.
//  Retry count clears on every accepted request.
//  req_valid while busy is ignored (ready=0); fields may change, captured copy is used.
//  Reset mid-sequence: outputs return to reset values immediately; a partial write set
//   already issued to the clock is not undone.
// STRUCTURE
//  Shared package: address constants ADDR_SEC=2'b00, ADDR_MIN=2'b01, ADDR_HR=2'b10;
//   limits SEC_MAX=59, MIN_MAX=59, HR_MAX=23; loader state encoding.
//  One sub-module: clk_time_inc (combinational +1 second with carry into min/hr),
//   used by VERIFY to form the accepted "ticked" readback value.
// TESTING
//  Request 13:45:30, readback mirrors writes -> load pulses at 10/13, 01/45, 00/30; done at 6.
//  Request 24:00:00 -> error pulse at cycle 1, no load pulse, ready back at cycle 2.
//  Request 23:59:59, readback 00:00:00 (tick during verify) -> done, no retry.
//  Readback minutes stuck at 0 for 07:12:05 -> 1+MAX_RETRY=4 write bursts, then error.
//  Reset low during WR_MIN -> load=0, ready=1 same cycle; next request starts from CHECK.
//  req_valid held high across done -> second request accepted the cycle after done.

Source files
------------

// File: rtl/clk_time_loader_pkg.sv
// Shared constants and types for the real-time clock load initiator.
// Holds field limits, clock register addresses and the loader state encoding.
package clk_time_loader_pkg;

    localparam logic [1:0] ADDR_SEC = 2'b00;
    localparam logic [1:0] ADDR_MIN = 2'b01;
    localparam logic [1:0] ADDR_HR  = 2'b10;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WR_HR,
        ST_WR_MIN,
        ST_WR_SEC,
        ST_VERIFY
    } loader_state_e;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

endpackage

// File: rtl/clk_time_inc.sv
// Combinational one-second advance of an hh:mm:ss value, carrying into minutes
// and hours and wrapping 23:59:59 to 00:00:00.
module clk_time_inc
    import clk_time_loader_pkg::*;
(
    input  hms_t t_i,
    output hms_t t_o
);

    always_comb begin
        t_o = t_i;
        if (t_i.sec >= SEC_MAX) begin
            t_o.sec = 6'd0;
            if (t_i.min >= MIN_MAX) begin
                t_o.min = 6'd0;
                t_o.hr  = (t_i.hr >= HR_MAX) ? 5'd0 : t_i.hr + 5'd1;
            end else begin
                t_o.min = t_i.min + 6'd1;
            end
        end else begin
            t_o.sec = t_i.sec + 6'd1;
        end
    end

endmodule

// File: rtl/clk_time_loader.sv
// Loads one hh:mm:ss request into the real-time clock (hours, minutes, seconds),
// reads it back and rewrites on mismatch until the retry budget runs out.
//
// state     | meaning
// ST_IDLE   | ready for a request, captures fields on valid&&ready
// ST_CHECK  | range-check captured fields, error pulse if out of range
// ST_WR_HR  | load strobe to hours register
// ST_WR_MIN | load strobe to minutes register
// ST_WR_SEC | load strobe to seconds register
// ST_VERIFY | one settle cycle, then compare readback (done / retry / error)
module clk_time_loader
    import clk_time_loader_pkg::*;
#(
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_hours,
    input  logic [5:0] req_minutes,
    input  logic [5:0] req_seconds,
    input  logic [5:0] q_seconds,
    input  logic [5:0] q_minutes,
    input  logic [4:0] q_hours,
    output logic       load,
    output logic [1:0] addrs,
    output logic [5:0] data_in,
    output logic       done,
    output logic       error
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    loader_state_e state_q, state_d;
    hms_t          cap_q, cap_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          vwait_q, vwait_d;
    logic          load_q, load_d;
    logic [1:0]    addrs_q, addrs_d;
    logic [5:0]    data_q, data_d;

    hms_t cap_inc;
    hms_t readback;
    logic range_bad;
    logic match;

    clk_time_inc u_inc (
        .t_i (cap_q),
        .t_o (cap_inc)
    );

    assign readback  = '{hr: q_hours, min: q_minutes, sec: q_seconds};
    assign range_bad = (cap_q.hr > HR_MAX) || (cap_q.min > MIN_MAX) || (cap_q.sec > SEC_MAX);
    // A base tick may land between the seconds write and the compare.
    assign match     = (readback == cap_q) || (readback == cap_inc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
            retry_q <= '0;
            vwait_q <= 1'b0;
            load_q  <= 1'b0;
            addrs_q <= ADDR_SEC;
            data_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            retry_q <= retry_d;
            vwait_q <= vwait_d;
            load_q  <= load_d;
            addrs_q <= addrs_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        retry_d   = retry_q;
        vwait_d   = 1'b0;
        req_ready = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cap_d   = '{hr: req_hours, min: req_minutes, sec: req_seconds};
                    retry_d = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (range_bad) begin
                    error   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_HR;
                end
            end
            ST_WR_HR:  state_d = ST_WR_MIN;
            ST_WR_MIN: state_d = ST_WR_SEC;
            ST_WR_SEC: begin
                state_d = ST_VERIFY;
                vwait_d = 1'b1;
            end
            ST_VERIFY: begin
                if (vwait_q) begin
                    state_d = ST_VERIFY;
                end else if (match) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_WR_HR;
                end else begin
                    error   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write strobes are registered so they line up with the WR_* states.
    always_comb begin
        load_d  = 1'b0;
        addrs_d = addrs_q;
        data_d  = data_q;
        case (state_d)
            ST_WR_HR: begin
                load_d  = 1'b1;
                addrs_d = ADDR_HR;
                data_d  = {1'b0, cap_d.hr};
            end
            ST_WR_MIN: begin
                load_d  = 1'b1;
                addrs_d = ADDR_MIN;
                data_d  = cap_d.min;
            end
            ST_WR_SEC: begin
                load_d  = 1'b1;
                addrs_d = ADDR_SEC;
                data_d  = cap_d.sec;
            end
            default: ;
        endcase
    end

    assign load    = load_q;
    assign addrs   = addrs_q;
    assign data_in = data_q;

endmodule

// File: tb/tb_clk_time_loader.sv
// Directed bench for clk_time_loader with a small behavioural clock model on the
// load interface; modes for a tick after the seconds write and stuck-at-0 minutes.
module tb_clk_time_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_hours;
    logic [5:0] req_minutes;
    logic [5:0] req_seconds;
    logic [5:0] q_seconds;
    logic [5:0] q_minutes;
    logic [4:0] q_hours;
    logic       load;
    logic [1:0] addrs;
    logic [5:0] data_in;
    logic       done;
    logic       error;

    int errors = 0;
    int checks = 0;

    logic [4:0] m_hr  = 5'd0;
    logic [5:0] m_min = 6'd0;
    logic [5:0] m_sec = 6'd0;
    bit tick_mode  = 1'b0;
    bit stuck_mode = 1'b0;

    logic       r_ld  [0:31];
    logic [1:0] r_ad  [0:31];
    logic [5:0] r_dt  [0:31];
    logic       r_dn  [0:31];
    logic       r_er  [0:31];
    logic       r_rdy [0:31];

    always #5 clk = ~clk;

    clk_time_loader #(.MAX_RETRY(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_hours   (req_hours),
        .req_minutes (req_minutes),
        .req_seconds (req_seconds),
        .q_seconds   (q_seconds),
        .q_minutes   (q_minutes),
        .q_hours     (q_hours),
        .load        (load),
        .addrs       (addrs),
        .data_in     (data_in),
        .done        (done),
        .error       (error)
    );

    // Behavioural clock registers written through the load interface.
    always @(posedge clk) begin
        if (load) begin
            case (addrs)
                2'b10: m_hr <= data_in[4:0];
                2'b01: m_min <= data_in;
                2'b00: begin
                    if (tick_mode && data_in == 6'd59) begin
                        m_sec <= 6'd0;
                        if (m_min == 6'd59) begin
                            m_min <= 6'd0;
                            m_hr  <= (m_hr == 5'd23) ? 5'd0 : m_hr + 5'd1;
                        end else begin
                            m_min <= m_min + 6'd1;
                        end
                    end else if (tick_mode) begin
                        m_sec <= data_in + 6'd1;
                    end else begin
                        m_sec <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_hours   = m_hr;
    assign q_minutes = stuck_mode ? 6'd0 : m_min;
    assign q_seconds = m_sec;

    // Issue one request (caller is at a negedge) and record outputs for n cycles.
    // Cycle k is sampled at the k-th negedge after the accepting edge.
    task automatic issue(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                         input bit hold, input logic [4:0] h2, input logic [5:0] m2,
                         input logic [5:0] s2, input int n);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: got %b want 1", req_ready);
        end
        req_hours = h; req_minutes = m; req_seconds = s; req_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= n && i < 32; i++) begin
            @(negedge clk);
            r_ld[i] = load; r_ad[i] = addrs; r_dt[i] = data_in;
            r_dn[i] = done; r_er[i] = error; r_rdy[i] = req_ready;
            if (i == 1) begin
                req_hours = h2; req_minutes = m2; req_seconds = s2;
                if (!hold) req_valid = 1'b0;
            end
            if (i == 8) req_valid = 1'b0;
        end
    endtask

    task automatic settle();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0;
        req_hours = 5'd0; req_minutes = 6'd0; req_seconds = 6'd0;
        #12;
        checks++;
        if ({req_ready, load, addrs, data_in, done, error} !== {1'b1, 1'b0, 2'b00, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b ld=%b ad=%b dt=%0d dn=%b er=%b want 1 0 00 0 0 0",
                     req_ready, load, addrs, data_in, done, error);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        int nld;
        issue(5'd13, 6'd45, 6'd30, 1'b0, 5'd0, 6'd0, 6'd0, 8);
        checks++;
        if (r_ld[1] !== 1'b0 || r_er[1] !== 1'b0) begin
            errors++; $display("FAIL clean_check_cycle: got ld=%b er=%b want 0 0", r_ld[1], r_er[1]);
        end
        checks++;
        if ({r_ld[2], r_ad[2], r_dt[2]} !== {1'b1, 2'b10, 6'd13}) begin
            errors++; $display("FAIL clean_wr_hr: got %b/%b/%0d want 1/10/13", r_ld[2], r_ad[2], r_dt[2]);
        end
        checks++;
        if ({r_ld[3], r_ad[3], r_dt[3]} !== {1'b1, 2'b01, 6'd45}) begin
            errors++; $display("FAIL clean_wr_min: got %b/%b/%0d want 1/01/45", r_ld[3], r_ad[3], r_dt[3]);
        end
        checks++;
        if ({r_ld[4], r_ad[4], r_dt[4]} !== {1'b1, 2'b00, 6'd30}) begin
            errors++; $display("FAIL clean_wr_sec: got %b/%b/%0d want 1/00/30", r_ld[4], r_ad[4], r_dt[4]);
        end
        checks++;
        if ({r_ld[5], r_ad[5], r_dt[5], r_dn[5]} !== {1'b0, 2'b00, 6'd30, 1'b0}) begin
            errors++; $display("FAIL clean_hold: got ld=%b ad=%b dt=%0d dn=%b want 0 00 30 0",
                               r_ld[5], r_ad[5], r_dt[5], r_dn[5]);
        end
        checks++;
        if ({r_dn[6], r_er[6], r_rdy[6]} !== 3'b100) begin
            errors++; $display("FAIL clean_done: got dn=%b er=%b rdy=%b want 1 0 0", r_dn[6], r_er[6], r_rdy[6]);
        end
        checks++;
        if ({r_dn[7], r_rdy[7]} !== 2'b01) begin
            errors++; $display("FAIL clean_after: got dn=%b rdy=%b want 0 1", r_dn[7], r_rdy[7]);
        end
        nld = 0;
        for (int i = 1; i <= 8; i++) nld += int'(r_ld[i]);
        checks++;
        if (nld != 3) begin
            errors++; $display("FAIL clean_load_count: got %0d want 3", nld);
        end
        settle();
    endtask

    task automatic test_range();
        logic [16:0] vec [0:2];
        int nld;
        vec[0] = {5'd24, 6'd0, 6'd0};
        vec[1] = {5'd0, 6'd60, 6'd0};
        vec[2] = {5'd0, 6'd0, 6'd60};
        for (int v = 0; v < 3; v++) begin
            issue(vec[v][16:12], vec[v][11:6], vec[v][5:0], 1'b0, 5'd0, 6'd0, 6'd0, 4);
            nld = 0;
            for (int i = 1; i <= 4; i++) nld += int'(r_ld[i]) + int'(r_dn[i]);
            checks++;
            if ({r_er[1], r_er[2], r_rdy[1], r_rdy[2]} !== 4'b1001 || nld != 0) begin
                errors++;
                $display("FAIL range_%0d: got er1=%b er2=%b rdy1=%b rdy2=%b load/done=%0d want 1 0 0 1 0",
                         v, r_er[1], r_er[2], r_rdy[1], r_rdy[2], nld);
            end
            settle();
        end
    endtask

    task automatic test_tick();
        tick_mode = 1'b1;
        issue(5'd23, 6'd59, 6'd59, 1'b0, 5'd0, 6'd0, 6'd0, 8);
        checks++;
        if ({r_dn[6], r_er[6], r_ld[7], r_ld[8]} !== 4'b1000) begin
            errors++; $display("FAIL tick_wrap: got dn=%b er=%b ld7=%b ld8=%b want 1 0 0 0",
                               r_dn[6], r_er[6], r_ld[7], r_ld[8]);
        end
        checks++;
        if ({q_hours, q_minutes, q_seconds} !== 17'd0) begin
            errors++; $display("FAIL tick_model: got %0d:%0d:%0d want 0:0:0", q_hours, q_minutes, q_seconds);
        end
        settle();
        issue(5'd13, 6'd45, 6'd30, 1'b0, 5'd0, 6'd0, 6'd0, 8);
        checks++;
        if ({r_dn[6], r_ld[7]} !== 2'b10) begin
            errors++; $display("FAIL tick_plain: got dn=%b ld7=%b want 1 0", r_dn[6], r_ld[7]);
        end
        tick_mode = 1'b0;
        settle();
    endtask

    task automatic test_retry();
        int nld, ndn, first_er;
        stuck_mode = 1'b1;
        issue(5'd7, 6'd12, 6'd5, 1'b0, 5'd0, 6'd0, 6'd0, 24);
        nld = 0; ndn = 0; first_er = 0;
        for (int i = 1; i <= 24; i++) begin
            nld += int'(r_ld[i]);
            ndn += int'(r_dn[i]);
            if (r_er[i] === 1'b1 && first_er == 0) first_er = i;
        end
        checks++;
        if (nld != 12 || ndn != 0) begin
            errors++; $display("FAIL retry_bursts: got loads=%0d dones=%0d want 12 0", nld, ndn);
        end
        checks++;
        if (first_er != 21) begin
            errors++; $display("FAIL retry_error_cycle: got %0d want 21", first_er);
        end
        checks++;
        if ({r_ld[17], r_ad[17], r_dt[17], r_rdy[22]} !== {1'b1, 2'b10, 6'd7, 1'b1}) begin
            errors++; $display("FAIL retry_last_burst: got ld=%b ad=%b dt=%0d rdy22=%b want 1 10 7 1",
                               r_ld[17], r_ad[17], r_dt[17], r_rdy[22]);
        end
        stuck_mode = 1'b0;
        settle();
    endtask

    task automatic test_reset_mid();
        req_hours = 5'd9; req_minutes = 6'd8; req_seconds = 6'd7; req_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        checks++;
        if ({load, addrs, data_in} !== {1'b1, 2'b01, 6'd8}) begin
            errors++; $display("FAIL mid_wr_min: got %b/%b/%0d want 1/01/8", load, addrs, data_in);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({load, req_ready, addrs, data_in, done, error} !== {1'b1 ^ 1'b1, 1'b1, 2'b00, 6'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mid_reset: got ld=%b rdy=%b ad=%b dt=%0d want 0 1 00 0",
                               load, req_ready, addrs, data_in);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(5'd5, 6'd6, 6'd7, 1'b0, 5'd0, 6'd0, 6'd0, 7);
        checks++;
        if ({r_ld[1], r_er[1], r_ld[2], r_ad[2], r_dt[2], r_dn[6]} !== {1'b0, 1'b0, 1'b1, 2'b10, 6'd5, 1'b1}) begin
            errors++; $display("FAIL mid_restart: got ld1=%b er1=%b ld2=%b ad2=%b dt2=%0d dn6=%b want 0 0 1 10 5 1",
                               r_ld[1], r_er[1], r_ld[2], r_ad[2], r_dt[2], r_dn[6]);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        issue(5'd1, 6'd2, 6'd3, 1'b1, 5'd2, 6'd3, 6'd4, 15);
        checks++;
        if ({r_dt[2], r_dt[3], r_dt[4], r_dn[6]} !== {6'd1, 6'd2, 6'd3, 1'b1}) begin
            errors++; $display("FAIL b2b_first: got %0d/%0d/%0d dn=%b want 1/2/3 1",
                               r_dt[2], r_dt[3], r_dt[4], r_dn[6]);
        end
        checks++;
        if ({r_rdy[7], r_rdy[8], r_ld[9], r_ad[9], r_dt[9]} !== {1'b1, 1'b0, 1'b1, 2'b10, 6'd2}) begin
            errors++; $display("FAIL b2b_accept: got rdy7=%b rdy8=%b ld9=%b ad9=%b dt9=%0d want 1 0 1 10 2",
                               r_rdy[7], r_rdy[8], r_ld[9], r_ad[9], r_dt[9]);
        end
        checks++;
        if ({r_dt[10], r_dt[11], r_dn[12], r_dn[13], r_er[13]} !== {6'd3, 6'd4, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL b2b_second: got %0d/%0d dn12=%b dn13=%b er13=%b want 3/4 0 1 0",
                               r_dt[10], r_dt[11], r_dn[12], r_dn[13], r_er[13]);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_range();
        test_tick();
        test_retry();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
